// File: rtl/amp_pwr_seq.sv
// Power-up / fault sequencer for N class-D amplifier channels.
// Releases sht_dwn after a settle time, filters amp faults and retries or locks out.
module amp_pwr_seq #(
   parameter int N_AMP     = 2,
   parameter int PWRUP_CYC = 250000,
   parameter int RETRY_CYC = 25000000,
   parameter int FLT_FILT  = 4,
   parameter int MAX_RETRY = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             seq_low,
   input  logic [N_AMP-1:0] Flt_n,
   input  logic             clr_flt,
   output logic             sht_dwn,
   output logic             amp_on,
   output logic             locked,
   output logic [N_AMP-1:0] flt_src,
   output logic [3:0]       retry_cnt,
   output logic [2:0]       state
);

   localparam int TMR_MAX = (PWRUP_CYC > RETRY_CYC) ? PWRUP_CYC : RETRY_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int FCNT_W  = $clog2(FLT_FILT + 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PWRUP   = 3'd1,
      ST_RUN     = 3'd2,
      ST_FAULT   = 3'd3,
      ST_LOCKOUT = 3'd4
   } state_t;

   state_t             state_reg, state_next;
   logic [TMR_W-1:0]   tmr_reg, tmr_next;
   logic [3:0]         retry_reg, retry_next;
   logic [N_AMP-1:0]   flt_src_reg, flt_src_next;
   logic               sht_dwn_reg, sht_dwn_next;
   logic               amp_on_reg, amp_on_next;
   logic               locked_reg, locked_next;
   logic [N_AMP-1:0]   flt;
   logic               any_flt;
   logic               flt_evt;

   // Per channel: 2-FF synchroniser, then a saturating low-time counter as glitch filter.
   genvar gi;
   generate
      for (gi = 0; gi < N_AMP; gi++) begin : g_ch
         logic [1:0]        sync_reg;
         logic [FCNT_W-1:0] cnt_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync_reg <= 2'b11;
               cnt_reg  <= '0;
            end else begin
               sync_reg <= {sync_reg[0], Flt_n[gi]};
               if (sync_reg[1])
                  cnt_reg <= '0;
               else if (cnt_reg != FCNT_W'(FLT_FILT))
                  cnt_reg <= cnt_reg + 1'b1;
            end
         end

         assign flt[gi] = (cnt_reg >= FCNT_W'(FLT_FILT));
      end
   endgenerate

   assign any_flt = |flt;
   assign flt_evt = any_flt && ((state_reg == ST_PWRUP) || (state_reg == ST_RUN));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         tmr_reg     <= '0;
         retry_reg   <= '0;
         flt_src_reg <= '0;
         sht_dwn_reg <= 1'b1;
         amp_on_reg  <= 1'b0;
         locked_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         tmr_reg     <= tmr_next;
         retry_reg   <= retry_next;
         flt_src_reg <= flt_src_next;
         sht_dwn_reg <= sht_dwn_next;
         amp_on_reg  <= amp_on_next;
         locked_reg  <= locked_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      retry_next = retry_reg;
      if (!en && (state_reg != ST_LOCKOUT)) begin
         state_next = ST_IDLE;
         retry_next = '0;
      end else if (flt_evt) begin
         if (retry_reg == 4'(MAX_RETRY)) begin
            state_next = ST_LOCKOUT;
         end else begin
            state_next = ST_FAULT;
            retry_next = retry_reg + 1'b1;
         end
      end else begin
         if (clr_flt)
            retry_next = '0;
         case (state_reg)
            ST_IDLE:
               if (en && seq_low && !any_flt)
                  state_next = ST_PWRUP;
            ST_PWRUP:
               if (tmr_reg == TMR_W'(PWRUP_CYC - 1))
                  state_next = ST_RUN;
            ST_RUN:
               state_next = ST_RUN;
            ST_FAULT:
               if (!any_flt && (tmr_reg == TMR_W'(RETRY_CYC - 1)))
                  state_next = ST_PWRUP;
            ST_LOCKOUT:
               // a fault present with the clear keeps us locked out
               if (clr_flt && !any_flt)
                  state_next = ST_IDLE;
            default:
               state_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      tmr_next = '0;
      if (state_next != state_reg)
         tmr_next = '0;
      else if ((state_reg == ST_FAULT) && any_flt)
         tmr_next = '0;
      else if (((state_reg == ST_PWRUP) || (state_reg == ST_FAULT)) &&
               (tmr_reg != TMR_W'(TMR_MAX)))
         tmr_next = tmr_reg + 1'b1;
      else if ((state_reg == ST_PWRUP) || (state_reg == ST_FAULT))
         tmr_next = tmr_reg;
   end

   // Set wins over clear so a fault qualifying during clr_flt is never lost.
   always_comb begin
      flt_src_next = (clr_flt ? '0 : flt_src_reg) | flt;
      sht_dwn_next = (state_next != ST_RUN);
      amp_on_next  = (state_next == ST_RUN);
      locked_next  = (state_next == ST_LOCKOUT);
   end

   assign sht_dwn   = sht_dwn_reg;
   assign amp_on    = amp_on_reg;
   assign locked    = locked_reg;
   assign flt_src   = flt_src_reg;
   assign retry_cnt = retry_reg;
   assign state     = state_reg;

endmodule

// File: tb/tb_amp_pwr_seq.sv
// Directed bench for amp_pwr_seq with short timing parameters.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_amp_pwr_seq;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_PWRUP   = 3'd1;
   localparam logic [2:0] S_RUN     = 3'd2;
   localparam logic [2:0] S_FAULT   = 3'd3;
   localparam logic [2:0] S_LOCKOUT = 3'd4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       seq_low;
   logic [1:0] Flt_n;
   logic       clr_flt;
   logic       sht_dwn;
   logic       amp_on;
   logic       locked;
   logic [1:0] flt_src;
   logic [3:0] retry_cnt;
   logic [2:0] state;

   int n_vec = 0;
   int n_err = 0;

   amp_pwr_seq #(
      .N_AMP     (2),
      .PWRUP_CYC (10),
      .RETRY_CYC (20),
      .FLT_FILT  (3),
      .MAX_RETRY (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .seq_low   (seq_low),
      .Flt_n     (Flt_n),
      .clr_flt   (clr_flt),
      .sht_dwn   (sht_dwn),
      .amp_on    (amp_on),
      .locked    (locked),
      .flt_src   (flt_src),
      .retry_cnt (retry_cnt),
      .state     (state)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // state plus the three state-decoded outputs
   task automatic expect_st(input string tag, input logic [2:0] st);
      check({tag, "/state"},   8'(state),   8'(st));
      check({tag, "/sht_dwn"}, 8'(sht_dwn), 8'(st != S_RUN));
      check({tag, "/amp_on"},  8'(amp_on),  8'(st == S_RUN));
      check({tag, "/locked"},  8'(locked),  8'(st == S_LOCKOUT));
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; seq_low = 1'b0; Flt_n = 2'b11; clr_flt = 1'b0;
      #12;
      expect_st("reset", S_IDLE);
      check("reset/flt_src", 8'(flt_src), 8'h00);
      check("reset/retry", 8'(retry_cnt), 8'h00);
      rst_n = 1'b1;
      tick(1);

      // 1: start-up sequence
      en = 1'b1;
      tick(4);
      expect_st("t1_idle", S_IDLE);
      seq_low = 1'b1;
      tick(1);
      expect_st("t1_pwrup", S_PWRUP);
      tick(9);
      expect_st("t1_pwrup_end", S_PWRUP);
      tick(1);
      expect_st("t1_run", S_RUN);
      seq_low = 1'b0;
      tick(3);
      expect_st("t1_seq_low_ignored", S_RUN);
      seq_low = 1'b1;

      // 2: short glitch ignored, held fault trips after 6 edges
      Flt_n = 2'b01;
      tick(2);
      Flt_n = 2'b11;
      tick(8);
      expect_st("t2_glitch", S_RUN);
      check("t2_glitch/flt_src", 8'(flt_src), 8'h00);
      Flt_n = 2'b01;
      tick(5);
      expect_st("t2_edge5", S_RUN);
      tick(1);
      expect_st("t2_edge6", S_FAULT);
      check("t2/flt_src", 8'(flt_src), 8'h02);
      check("t2/retry", 8'(retry_cnt), 8'h01);

      // 3: held fault freezes the cool-down; release -> PWRUP 23 edges later
      tick(30);
      expect_st("t3_held", S_FAULT);
      Flt_n = 2'b11;
      tick(22);
      expect_st("t3_cool22", S_FAULT);
      tick(1);
      expect_st("t3_cool23", S_PWRUP);
      tick(9);
      expect_st("t3_pwrup_end", S_PWRUP);
      tick(1);
      expect_st("t3_run", S_RUN);
      check("t3/retry", 8'(retry_cnt), 8'h01);

      // 4: en low clears retries; three fault events -> LOCKOUT
      en = 1'b0;
      tick(1);
      expect_st("t4_en_low", S_IDLE);
      check("t4_en_low/retry", 8'(retry_cnt), 8'h00);
      check("t4_en_low/flt_src", 8'(flt_src), 8'h02);
      en = 1'b1;
      tick(1);
      expect_st("t4_restart", S_PWRUP);
      for (int ev = 0; ev < 2; ev++) begin
         Flt_n = 2'b10;
         tick(6);
         expect_st("t4_evt", S_FAULT);
         check("t4_evt/retry", 8'(retry_cnt), 8'(ev + 1));
         Flt_n = 2'b11;
         tick(23);
         expect_st("t4_retry", S_PWRUP);
      end
      Flt_n = 2'b10;
      tick(6);
      expect_st("t4_lockout", S_LOCKOUT);
      check("t4_lockout/retry", 8'(retry_cnt), 8'h02);
      check("t4_lockout/flt_src", 8'(flt_src), 8'h03);
      clr_flt = 1'b1;
      tick(1);
      clr_flt = 1'b0;
      expect_st("t4_clr_with_fault", S_LOCKOUT);
      Flt_n = 2'b11;
      tick(5);
      en = 1'b0;
      tick(3);
      expect_st("t4_en_low_locked", S_LOCKOUT);
      en = 1'b1;
      tick(2);
      expect_st("t4_en_high_locked", S_LOCKOUT);
      clr_flt = 1'b1;
      tick(1);
      clr_flt = 1'b0;
      expect_st("t4_cleared", S_IDLE);
      check("t4_cleared/flt_src", 8'(flt_src), 8'h00);
      check("t4_cleared/retry", 8'(retry_cnt), 8'h00);
      tick(1);
      expect_st("t4_after_clr", S_PWRUP);

      // 5: clr_flt in the cycle a new fault qualifies keeps that bit
      en = 1'b0;
      tick(1);
      expect_st("t5_idle", S_IDLE);
      Flt_n = 2'b01;
      tick(6);
      check("t5_ch1/flt_src", 8'(flt_src), 8'h02);
      Flt_n = 2'b11;
      tick(5);
      Flt_n = 2'b10;
      tick(5);
      clr_flt = 1'b1;
      tick(1);
      clr_flt = 1'b0;
      check("t5_set_wins/flt_src", 8'(flt_src), 8'h01);
      Flt_n = 2'b11;
      tick(5);

      // 6: async reset mid-PWRUP, then a full-length restart
      en = 1'b1;
      tick(1);
      expect_st("t6_pwrup", S_PWRUP);
      tick(7);
      rst_n = 1'b0;
      #1;
      expect_st("t6_reset", S_IDLE);
      check("t6_reset/flt_src", 8'(flt_src), 8'h00);
      check("t6_reset/retry", 8'(retry_cnt), 8'h00);
      #2;
      rst_n = 1'b1;
      tick(1);
      expect_st("t6_restart", S_PWRUP);
      tick(9);
      expect_st("t6_restart_end", S_PWRUP);
      tick(1);
      expect_st("t6_run", S_RUN);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
